board_scanner: RTL

BOARD_SCANNER -- requirements
Module: board_scanner

---
 rtl/board_scanner.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/board_scanner.sv
// board_scanner: reads a 3x3 tic-tac-toe board one cell per cycle into a
// shadow copy, then finds the winner, the winning line and draw status.
// Optional feature macro: BOARD_ILLEGAL_CHECK_EN (board consistency check
// driving `illegal`; without it `illegal` is tied to 0).
module board_scanner (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       rd_en,
  output logic [3:0] rd_addr,
  input  logic [1:0] rd_data,
  output logic       busy,
  output logic       done,
  output logic [1:0] winner,
  output logic [2:0] win_line,
  output logic       draw,
  output logic       illegal
);

  localparam logic [1:0] CELL_X = 2'b01;
  localparam logic [1:0] CELL_O = 2'b10;

  typedef enum logic [2:0] {IDLE, READ, WAIT, EVAL, REPORT} state_t;

  state_t          state, state_nxt;
  logic [3:0]      cnt;
  logic            cap_vld;
  logic [3:0]      cap_idx;
  logic [8:0][1:0] board;

  // Cell indices {a,b,c} of each line: rows, columns, main and anti diagonal.
  function automatic logic [11:0] line_cells(input logic [2:0] l);
    case (l)
      3'd0:    line_cells = {4'd0, 4'd1, 4'd2};
      3'd1:    line_cells = {4'd3, 4'd4, 4'd5};
      3'd2:    line_cells = {4'd6, 4'd7, 4'd8};
      3'd3:    line_cells = {4'd0, 4'd3, 4'd6};
      3'd4:    line_cells = {4'd1, 4'd4, 4'd7};
      3'd5:    line_cells = {4'd2, 4'd5, 4'd8};
      3'd6:    line_cells = {4'd0, 4'd4, 4'd8};
      default: line_cells = {4'd2, 4'd4, 4'd6};
    endcase
  endfunction

  // State register; reset aborts any scan in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; start only matters in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = READ;
      READ:    if (cnt == 4'd8) state_nxt = WAIT;
      WAIT:    state_nxt = EVAL;
      EVAL:    state_nxt = REPORT;
      REPORT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Read address counter, walks 0..8 while in READ and rests at 0 otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                cnt <= 4'd0;
    else if (state == READ) cnt <= cnt + 4'd1;
    else                    cnt <= 4'd0;
  end

  assign rd_en   = (state == READ);
  assign rd_addr = (state == READ) ? cnt : 4'd0;
  assign busy    = (state != IDLE);

  // Shadow board: data returns one cycle after the strobe, so the issued
  // index is delayed alongside it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_vld <= 1'b0;
      cap_idx <= 4'd0;
      board   <= '0;
    end else begin
      cap_vld <= rd_en;
      cap_idx <= rd_addr;
      if (cap_vld && cap_idx < 4'd9) board[cap_idx] <= rd_data;
    end
  end

  logic        w_found;
  logic [1:0]  w_who;
  logic [2:0]  w_idx;
  logic        full;
  logic [11:0] t;
  logic [1:0]  ca, cb, cc;

  // Line search: scanning high to low lets the lowest winning line overwrite.
  always_comb begin
    w_found = 1'b0;
    w_who   = 2'b00;
    w_idx   = 3'd0;
    full    = 1'b1;
    t       = '0;
    ca      = 2'b00;
    cb      = 2'b00;
    cc      = 2'b00;
    for (int l = 7; l >= 0; l--) begin
      t  = line_cells(3'(l));
      ca = board[t[11:8]];
      cb = board[t[7:4]];
      cc = board[t[3:0]];
      if (ca == cb && cb == cc && (ca == CELL_X || ca == CELL_O)) begin
        w_found = 1'b1;
        w_who   = ca;
        w_idx   = 3'(l);
      end
    end
    for (int i = 0; i < 9; i++)
      if (board[i] != CELL_X && board[i] != CELL_O) full = 1'b0;
  end

  // Result registers, loaded once per scan in EVAL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      winner   <= 2'b00;
      win_line <= 3'd0;
      draw     <= 1'b0;
    end else if (state == EVAL) begin
      winner   <= w_who;
      win_line <= w_idx;
      draw     <= !w_found && full;
    end
  end

  // done is high exactly for the REPORT cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) done <= 1'b0;
    else     done <= (state == EVAL);
  end

`ifdef BOARD_ILLEGAL_CHECK_EN
  logic [3:0]  nx, no;
  logic        any_inv, x_line, o_line, ill_nxt;
  logic [11:0] u;

  // Consistency: no invalid cells, move counts within one, single owner of lines.
  always_comb begin
    nx      = 4'd0;
    no      = 4'd0;
    any_inv = 1'b0;
    x_line  = 1'b0;
    o_line  = 1'b0;
    u       = '0;
    for (int i = 0; i < 9; i++) begin
      if (board[i] == CELL_X) nx = nx + 4'd1;
      if (board[i] == CELL_O) no = no + 4'd1;
      if (board[i] == 2'b11)  any_inv = 1'b1;
    end
    for (int l = 0; l < 8; l++) begin
      u = line_cells(3'(l));
      if (board[u[11:8]] == CELL_X && board[u[7:4]] == CELL_X && board[u[3:0]] == CELL_X)
        x_line = 1'b1;
      if (board[u[11:8]] == CELL_O && board[u[7:4]] == CELL_O && board[u[3:0]] == CELL_O)
        o_line = 1'b1;
    end
    ill_nxt = any_inv || (x_line && o_line) ||
              ((nx > no) ? (nx - no > 4'd1) : (no - nx > 4'd1));
  end

  // Illegal flag register, loaded alongside the other results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                illegal <= 1'b0;
    else if (state == EVAL) illegal <= ill_nxt;
  end
`else
  assign illegal = 1'b0;
`endif

endmodule
